// File: rtl/adder_pkg.sv
// Shared definitions for the serial add/subtract unit.
//   state_t       : controller states (IDLE, RUN)
//   calc_ndig()   : number of digit slices in a word (WIDTH / DIGIT)
//   calc_cnt_w()  : digit counter width, clog2(NDIG) with a minimum of 1
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int calc_cnt_w(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_fa.sv
// One W-bit adder slice: {co, s} = a + b + cin. Purely combinational.
// Ports:
//   a, b : W-bit digit operands
//   cin  : carry into the slice
//   s    : W-bit digit sum
//   co   : carry out of the slice
module digit_fa #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         co
);

  // Zero-extend every term so the W+1-bit sum keeps the carry.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit. One DIGIT-bit slice is added per clock,
// least-significant digit first, through a single digit_fa and a 1-bit
// registered carry, so a WIDTH-bit result takes WIDTH/DIGIT cycles.
// Ports:
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   start    : request, accepted only while busy=0
//   op_sub   : 0 = a+b+cin, 1 = a-b (cin ignored); sampled with start
//   a, b     : WIDTH-bit operands; sampled with start
//   cin      : carry-in for add; sampled with start
//   busy     : operation in progress
//   done     : one-cycle pulse when sum/cout/overflow are updated
//   sum      : result, held stable between completions
//   cout     : unsigned carry-out (subtract: 1 = no borrow, a >= b)
//   overflow : two's-complement signed overflow
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_q;       // operand A as sampled
  logic [WIDTH-1:0] b_q;       // operand B, already inverted for subtract
  logic [WIDTH-1:0] res_q;     // result shift register, fills from the top
  logic             carry_q;
  logic [CNT_W-1:0] cnt;

  logic [DIGIT-1:0]       a_dig;
  logic [DIGIT-1:0]       b_dig;
  logic [DIGIT-1:0]       s_dig;
  logic                   co_dig;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;

  assign a_dig = a_q[int'(cnt) * DIGIT +: DIGIT];
  assign b_dig = b_q[int'(cnt) * DIGIT +: DIGIT];

  digit_fa #(.W(DIGIT)) u_fa (
    .a   (a_dig),
    .b   (b_dig),
    .cin (carry_q),
    .s   (s_dig),
    .co  (co_dig)
  );

  // New digit enters at the top and the register shifts right by one digit;
  // after NDIG steps the first digit has reached bit 0. Concatenating first
  // keeps the slice legal even when DIGIT == WIDTH.
  assign res_cat  = {s_dig, res_q};
  assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only control and visible outputs are reset; the operand,
      // result and carry registers are always reloaded before use.
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= op_sub ? ~b : b;
            carry_q <= op_sub ? 1'b1 : cin;   // a - b == a + ~b + 1
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_next;
          carry_q <= co_dig;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_DIG) begin
            sum      <= res_next;
            cout     <= co_dig;
            // Signed overflow: both effective operands share a sign that
            // the result does not.
            overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (res_next[WIDTH-1] != a_q[WIDTH-1]);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder. Two instances: DIGIT=1 (u1, 8-cycle
// latency) and DIGIT=4 (u4, 2-cycle latency). The stimulus pushes the
// hand-computed result and the cycle at which done must appear; a monitor
// per instance pops and compares on every done pulse.
module tb_serial_adder;

  typedef struct {
    logic [7:0]  sum;
    logic        cout;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t q1[$];
  exp_t q4[$];

  // DIGIT = 1 instance
  logic       rst1, start1, op_sub1, cin1;
  logic [7:0] a1, b1;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;

  // DIGIT = 4 instance
  logic       rst4, start4, op_sub4, cin4;
  logic [7:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .op_sub(op_sub1), .a(a1), .b(b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .overflow(ovf1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst4), .start(start4), .op_sub(op_sub4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .overflow(ovf4)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitors: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) check("u1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        check("u1_sum", sum1, e.sum);
        check("u1_cout", cout1, e.cout);
        check("u1_ovf", ovf1, e.ovf);
        check("u1_done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) check("u4_unexpected_done", 1, 0);
      else begin
        e = q4.pop_front();
        check("u4_sum", sum4, e.sum);
        check("u4_cout", cout4, e.cout);
        check("u4_ovf", ovf4, e.ovf);
        check("u4_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one request on u1 for a single cycle; done is due 8 edges after
  // the accepting edge.
  task automatic issue1(input logic sub, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es, input logic ec,
                        input logic eo);
    exp_t e;
    @(negedge clk);
    start1 = 1'b1; op_sub1 = sub; a1 = a; b1 = b; cin1 = c;
    e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 1 + 8;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0; a1 = 8'hA5; b1 = 8'h5A; op_sub1 = ~sub; cin1 = ~c;
  endtask

  task automatic issue4(input logic sub, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es, input logic ec,
                        input logic eo);
    exp_t e;
    @(negedge clk);
    start4 = 1'b1; op_sub4 = sub; a4 = a; b4 = b; cin4 = c;
    e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 1 + 2;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0; a4 = 8'hA5; b4 = 8'h5A; op_sub4 = ~sub; cin4 = ~c;
  endtask

  task automatic drain1(input string name);
    int left = 40;
    while (q1.size() != 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    @(negedge clk);
    if (left == 0) check(name, 0, 1);
  endtask

  task automatic drain4(input string name);
    int left = 40;
    while (q4.size() != 0 && left > 0) begin
      @(negedge clk);
      left--;
    end
    @(negedge clk);
    if (left == 0) check(name, 0, 1);
  endtask

  // Back-to-back vectors for u4: {op_sub, a, b, cin, sum, cout, ovf}
  logic       bb_sub[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] bb_a[4]    = '{8'h12, 8'hF0, 8'h10, 8'h7F};
  logic [7:0] bb_b[4]    = '{8'h34, 8'h20, 8'h20, 8'h01};
  logic       bb_cin[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] bb_sum[4]  = '{8'h46, 8'h11, 8'hF0, 8'h80};
  logic       bb_cout[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic       bb_ovf[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst1 = 1'b1; start1 = 1'b0; op_sub1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; op_sub4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);
    check("rst_sum1", sum1, 0);
    check("rst_cout1", cout1, 0);
    check("rst_ovf1", ovf1, 0);
    check("rst_busy4", busy4, 0);
    check("rst_sum4", sum4, 0);
    rst1 = 1'b0; rst4 = 1'b0;

    // DIGIT=1 directed arithmetic
    issue1(1'b0, 8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0); drain1("to_add_200_100");
    issue1(1'b0, 8'd100, 8'd100, 1'b0, 8'hC8,  1'b0, 1'b1); drain1("to_add_100_100");
    issue1(1'b0, 8'hFF,  8'h00,  1'b1, 8'h00,  1'b1, 1'b0); drain1("to_add_ff_cin");
    issue1(1'b1, 8'd5,   8'd7,   1'b1, 8'hFE,  1'b0, 1'b0); drain1("to_sub_5_7");
    issue1(1'b1, 8'h80,  8'h01,  1'b0, 8'h7F,  1'b1, 1'b1); drain1("to_sub_80_01");
    issue1(1'b1, 8'd7,   8'd5,   1'b0, 8'h02,  1'b1, 1'b0); drain1("to_sub_7_5");

    // Start pulses during RUN cycles 2-5 must be ignored
    issue1(1'b0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      start1 = 1'b1; op_sub1 = 1'b1; a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b1;
    end
    @(negedge clk);
    start1 = 1'b0;
    drain1("to_ignore_start");
    repeat (10) @(negedge clk);   // any extra done is flagged by the monitor
    check("u1_queue_after_ignore", q1.size(), 0);

    // Reset in RUN cycle 3 aborts without a done
    issue1(1'b0, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst1 = 1'b1;
    q1.delete();
    @(negedge clk);
    rst1 = 1'b0;
    check("abort_busy", busy1, 0);
    check("abort_done", done1, 0);
    check("abort_sum", sum1, 0);
    check("abort_cout", cout1, 0);
    check("abort_ovf", ovf1, 0);
    repeat (12) @(negedge clk);
    check("abort_still_idle", busy1, 0);
    issue1(1'b0, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1); drain1("to_after_reset");

    // DIGIT=4: two-cycle latency
    issue4(1'b0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0); drain4("to_u4_single");

    // DIGIT=4: start held high every cycle; accepts land every 3 cycles, the
    // operands in between are junk that must never be sampled.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start4 = 1'b1;
      if (i % 3 == 0) begin
        exp_t e;
        op_sub4 = bb_sub[i/3]; a4 = bb_a[i/3]; b4 = bb_b[i/3]; cin4 = bb_cin[i/3];
        e.sum = bb_sum[i/3]; e.cout = bb_cout[i/3]; e.ovf = bb_ovf[i/3];
        e.cyc = cyc + 1 + 2;
        q4.push_back(e);
      end else begin
        op_sub4 = 1'b1; a4 = 8'hEE; b4 = 8'h77; cin4 = 1'b1;
      end
    end
    @(negedge clk);
    start4 = 1'b0;
    drain4("to_u4_stream");

    check("u1_queue_empty", q1.size(), 0);
    check("u4_queue_empty", q4.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
